// File: rtl/tx_pcrc.sv
// rtl/tx_pcrc.sv - 13-bit PCRC accumulator and MSB-first field serializer
//
// Purpose:
//   Builds a 13-bit CRC (generator 13'h19E7) over the transmitted bus bits.
//   On request, the CRC is sent out as a 13-bit field, MSB first. The block
//   has two states:
//     ACCUM - collects one bit per accepted pcrc_enable strobe.
//     SEND  - moves the serializer forward by one bit per accepted bit_tick.
//   Stuff bits are excluded from both the CRC and the field timing.
//
// Ports:
//   clk          in   1   system clock; all state changes on the rising edge
//   g_rst        in   1   synchronous active-high reset
//   tx_bit       in   1   current transmitted bus bit
//   pcrc_enable  in   1   strobe: fold tx_bit into the accumulator (ACCUM only)
//   stuff_bit    in   1   current bit is a stuff bit; blocks accumulate/advance
//   initialize   in   1   start-of-frame clear
//   tx_success   in   1   frame transmitted OK; clear
//   rx_success   in   1   frame received / arbitration lost; clear
//   pcrc_send    in   1   start serializing the PCRC field (ACCUM only)
//   bit_tick     in   1   strobe: advance the serializer by one bus bit
//   pcrc_bit     out  1   field bit to drive on the bus (0 outside SEND)
//   pcrc_busy    out  1   high while in SEND
//   pcrc_done    out  1   one-cycle pulse after the 13th field bit is consumed
//   pcrc_val     out  13  current accumulator value

module tx_pcrc (
  input  logic        clk,
  input  logic        g_rst,
  input  logic        tx_bit,
  input  logic        pcrc_enable,
  input  logic        stuff_bit,
  input  logic        initialize,
  input  logic        tx_success,
  input  logic        rx_success,
  input  logic        pcrc_send,
  input  logic        bit_tick,
  output logic        pcrc_bit,
  output logic        pcrc_busy,
  output logic        pcrc_done,
  output logic [12:0] pcrc_val
);

  localparam logic [12:0] PCRC_POLY = 13'h19E7;
  localparam logic [3:0]  LAST_BIT  = 4'd12;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] val_q,   val_d;
  logic [12:0] sreg_q,  sreg_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        done_q,  done_d;

  logic        frame_clear;
  logic        crc_fb;
  logic [12:0] crc_shift;
  logic [12:0] crc_next;

  // Any of the three frame-boundary events clears everything. Together they
  // outrank every other request except reset.
  assign frame_clear = tx_success | rx_success | initialize;

  // One serial step of the CRC: shift left, then XOR the generator in when
  // the incoming bit differs from the bit that is shifted out.
  assign crc_fb    = tx_bit ^ val_q[12];
  assign crc_shift = {val_q[11:0], 1'b0};
  assign crc_next  = crc_fb ? (crc_shift ^ PCRC_POLY) : crc_shift;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (frame_clear) begin
      // Aborting mid-SEND leaves done_d low, so no completion pulse is produced.
      state_d = ACCUM;
      val_d   = '0;
      sreg_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (pcrc_send) begin
            // pcrc_send outranks pcrc_enable, so a bit strobed in this same
            // cycle is dropped. The snapshot below is the CRC as it was.
            sreg_d  = val_q;
            cnt_d   = '0;
            state_d = SEND;
          end else if (pcrc_enable && !stuff_bit) begin
            val_d = crc_next;
          end
        end

        SEND: begin
          // pcrc_send and pcrc_enable are ignored in this state. pcrc_val
          // holds, so the field always matches the snapshot taken.
          if (bit_tick && !stuff_bit) begin
            if (cnt_q == LAST_BIT) begin
              done_d  = 1'b1;
              val_d   = '0;
              sreg_d  = '0;
              cnt_d   = '0;
              state_d = ACCUM;
            end else begin
              sreg_d = {sreg_q[11:0], 1'b0};
              cnt_d  = cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (g_rst) begin
      state_q <= ACCUM;
      val_q   <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Every output comes straight from flops. pcrc_bit is gated by the state,
  // so it stays at 0 while in ACCUM.
  assign pcrc_busy = (state_q == SEND);
  assign pcrc_bit  = (state_q == SEND) & sreg_q[12];
  assign pcrc_done = done_q;
  assign pcrc_val  = val_q;

endmodule

// File: tb/tb_tx_pcrc.sv
// tb/tb_tx_pcrc.sv - directed self-checking bench for tx_pcrc

module tb_tx_pcrc;

  logic        clk = 1'b0;
  logic        g_rst;
  logic        tx_bit;
  logic        pcrc_enable;
  logic        stuff_bit;
  logic        initialize;
  logic        tx_success;
  logic        rx_success;
  logic        pcrc_send;
  logic        bit_tick;
  logic        pcrc_bit;
  logic        pcrc_busy;
  logic        pcrc_done;
  logic [12:0] pcrc_val;

  int compared   = 0;
  int mismatched = 0;

  tx_pcrc dut (
    .clk         (clk),
    .g_rst       (g_rst),
    .tx_bit      (tx_bit),
    .pcrc_enable (pcrc_enable),
    .stuff_bit   (stuff_bit),
    .initialize  (initialize),
    .tx_success  (tx_success),
    .rx_success  (rx_success),
    .pcrc_send   (pcrc_send),
    .bit_tick    (bit_tick),
    .pcrc_bit    (pcrc_bit),
    .pcrc_busy   (pcrc_busy),
    .pcrc_done   (pcrc_done),
    .pcrc_val    (pcrc_val)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    tx_bit      = 1'b0;
    pcrc_enable = 1'b0;
    stuff_bit   = 1'b0;
    initialize  = 1'b0;
    tx_success  = 1'b0;
    rx_success  = 1'b0;
    pcrc_send   = 1'b0;
    bit_tick    = 1'b0;
    g_rst       = 1'b0;
  endtask

  // Applies the current inputs for one edge, then returns 1 time unit after it,
  // with all strobes already put back to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  function automatic logic [12:0] ref_crc(input logic [12:0] v, input logic b);
    logic [12:0] t;
    t = {v[11:0], 1'b0};
    return (b ^ v[12]) ? (t ^ 13'h19E7) : t;
  endfunction

  task automatic do_reset();
    idle_inputs();
    g_rst = 1'b1;
    step();
  endtask

  task automatic strobe(input logic b, input logic stuff);
    tx_bit      = b;
    pcrc_enable = 1'b1;
    stuff_bit   = stuff;
    step();
  endtask

  task automatic tick(input logic stuff);
    bit_tick  = 1'b1;
    stuff_bit = stuff;
    step();
  endtask

  logic [12:0] exp_bits;
  logic [12:0] ref_v;

  initial begin
    idle_inputs();
    #1;

    // Reset is asserted while other inputs are noisy; the outputs must still come up at zero.
    g_rst = 1'b1; tx_bit = 1'b1; pcrc_enable = 1'b1; pcrc_send = 1'b1;
    step();
    chk("rst_val",  pcrc_val, 13'h0000);
    chk("rst_bit",  {12'd0, pcrc_bit},  13'd0);
    chk("rst_busy", {12'd0, pcrc_busy}, 13'd0);
    chk("rst_done", {12'd0, pcrc_done}, 13'd0);

    // Two accumulation steps: input bit 1, then input bit 0.
    strobe(1'b1, 1'b0);
    chk("acc_1", pcrc_val, 13'h19E7);
    strobe(1'b0, 1'b0);
    chk("acc_10", pcrc_val, 13'h0A29);
    chk("acc_bit0_idle", {12'd0, pcrc_bit}, 13'd0);

    // Thirty zero bits from the cleared state leave the CRC at zero.
    do_reset();
    for (int i = 0; i < 30; i++) strobe(1'b0, 1'b0);
    chk("zeros30", pcrc_val, 13'h0000);

    // A stuff bit is not counted in the CRC.
    strobe(1'b1, 1'b1);
    chk("stuff_hold", pcrc_val, 13'h0000);
    strobe(1'b1, 1'b0);
    chk("stuff_then_data", pcrc_val, 13'h19E7);

    // Serialize 13'h19E7 with one stuffed tick inserted after the sixth bit.
    exp_bits = 13'b1_1001_1110_0111;
    ref_v = ref_crc(13'h0000, 1'b1);
    tx_bit = 1'b0; pcrc_enable = 1'b1; pcrc_send = 1'b1;   // this enable strobe must be dropped
    step();
    chk("send_busy", {12'd0, pcrc_busy}, 13'd1);
    chk("send_val_hold", pcrc_val, 13'h19E7);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("bit%0d", i), {12'd0, pcrc_bit}, {12'd0, exp_bits[12-i]});
      chk($sformatf("busy%0d", i), {12'd0, pcrc_busy}, 13'd1);
      chk($sformatf("nodone%0d", i), {12'd0, pcrc_done}, 13'd0);
      ref_v = ref_crc(ref_v, pcrc_bit);
      if (i == 5) begin
        tick(1'b1);
        chk("stuff_tick_bit", {12'd0, pcrc_bit}, {12'd0, exp_bits[12-i]});
      end
      if (i == 7) begin
        // pcrc_enable and pcrc_send are both ignored in SEND.
        tx_bit = 1'b1; pcrc_enable = 1'b1; pcrc_send = 1'b1;
        step();
        chk("send_ignore_val", pcrc_val, 13'h19E7);
        chk("send_ignore_bit", {12'd0, pcrc_bit}, {12'd0, exp_bits[12-i]});
      end
      tick(1'b0);
    end
    chk("done_pulse", {12'd0, pcrc_done}, 13'd1);
    chk("done_busy",  {12'd0, pcrc_busy}, 13'd0);
    chk("done_val",   pcrc_val, 13'h0000);
    chk("ref_residue", ref_v, 13'h0000);
    step();
    chk("done_single", {12'd0, pcrc_done}, 13'd0);
    chk("accum_bit0",  {12'd0, pcrc_bit},  13'd0);

    // An initialize after five accepted ticks aborts the field with no done pulse.
    strobe(1'b1, 1'b0);
    pcrc_send = 1'b1;
    step();
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("abort_pre_bit", {12'd0, pcrc_bit}, {12'd0, exp_bits[7]});
    initialize = 1'b1; bit_tick = 1'b1;
    step();
    chk("abort_busy", {12'd0, pcrc_busy}, 13'd0);
    chk("abort_val",  pcrc_val, 13'h0000);
    chk("abort_bit",  {12'd0, pcrc_bit},  13'd0);
    chk("abort_done", {12'd0, pcrc_done}, 13'd0);
    step();
    chk("abort_done2", {12'd0, pcrc_done}, 13'd0);

    // When initialize and pcrc_send come in the same cycle, initialize wins.
    strobe(1'b1, 1'b0);
    initialize = 1'b1; pcrc_send = 1'b1;
    step();
    chk("init_send_busy", {12'd0, pcrc_busy}, 13'd0);
    chk("init_send_val",  pcrc_val, 13'h0000);

    // A reset in the middle of SEND gives no done pulse.
    strobe(1'b1, 1'b0);
    pcrc_send = 1'b1;
    step();
    for (int i = 0; i < 12; i++) tick(1'b0);
    g_rst = 1'b1; bit_tick = 1'b1;
    step();
    chk("rst_send_done", {12'd0, pcrc_done}, 13'd0);
    chk("rst_send_busy", {12'd0, pcrc_busy}, 13'd0);
    step();
    chk("rst_send_done2", {12'd0, pcrc_done}, 13'd0);

    // rx_success clears the accumulator.
    strobe(1'b1, 1'b0);
    rx_success = 1'b1; pcrc_enable = 1'b1; tx_bit = 1'b1;
    step();
    chk("rx_clear", pcrc_val, 13'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tx_pcrc.md
TX_PCRC -- requirements
Module: tx_pcrc

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk, g_rst.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 g_rst  input  1  synchronous active-high reset.
REQ-004 tx_bit  input  1  current transmitted bus bit, sampled for CRC accumulation.
REQ-005 pcrc_enable  input  1  one-cycle strobe; accumulate tx_bit this cycle.
REQ-006 stuff_bit  input  1  current bit is a stuff bit; blocks accumulation and serialization advance.
REQ-007 initialize  input  1  start-of-frame clear.
REQ-008 tx_success  input  1  frame transmitted OK; clear.
REQ-009 rx_success  input  1  frame received OK, node lost arbitration or is receiver; clear.
REQ-010 pcrc_send  input  1  request to start serializing the PCRC field.
REQ-011 bit_tick  input  1  one-cycle strobe; advance serializer by one bus bit.
REQ-012 pcrc_bit  output  1  PCRC field bit to drive on bus, MSB first.
REQ-013 pcrc_busy  output  1  high while in SEND.
REQ-014 pcrc_done  output  1  one-cycle pulse after the 13th field bit is consumed.
REQ-015 pcrc_val  output  13  current accumulator value.

Function
REQ-016 The block SHALL have states ACCUM and SEND; ACCUM is the reset state.
REQ-017 In ACCUM, on pcrc_enable=1 and stuff_bit=0, with n = tx_bit XOR pcrc_val[12] and t = {pcrc_val[11:0],0}, pcrc_val SHALL become t XOR 13'h19E7 if n=1, else t.
REQ-018 In ACCUM, pcrc_enable with stuff_bit=1 SHALL leave pcrc_val unchanged.
REQ-019 In ACCUM, pcrc_send=1 SHALL copy pcrc_val into a 13-bit shift register, clear the 4-bit bit counter, and enter SEND next cycle; pcrc_enable in that same cycle SHALL be ignored.
REQ-020 In SEND, pcrc_bit SHALL equal shift register bit 12; pcrc_val SHALL hold and pcrc_enable SHALL be ignored.
REQ-021 In SEND, bit_tick=1 with stuff_bit=0 SHALL shift the register left by one (zero fill) and increment the counter; bit_tick with stuff_bit=1 SHALL change nothing.
REQ-022 The accepted bit_tick with counter=12 SHALL assert pcrc_done for exactly the following cycle, clear pcrc_val and the shift register, and return to ACCUM.
REQ-023 pcrc_send while in SEND SHALL be ignored.
REQ-024 In ACCUM, pcrc_bit SHALL be 0 and pcrc_busy SHALL be 0.
REQ-025 Priority SHALL be: g_rst > (tx_success or rx_success or initialize) > pcrc_send > pcrc_enable/bit_tick.
REQ-026 tx_success, rx_success or initialize in any state, including mid-SEND, SHALL clear pcrc_val, shift register and counter, force ACCUM, and suppress pcrc_done.
REQ-027 The counter SHALL never exceed 12; no wrap-around.

Reset
REQ-028 On g_rst=1 at a clock edge, outputs SHALL be pcrc_val=13'h0000, pcrc_bit=0, pcrc_busy=0, pcrc_done=0; state SHALL be ACCUM; counter 0.
REQ-029 Reset asserted mid-SEND SHALL abort serialization with no pcrc_done pulse.

Verification
REQ-030 Reset, then one pcrc_enable with tx_bit=1 -> pcrc_val=13'h19E7; a second with tx_bit=0 -> 13'h0A29.
REQ-031 Thirty pcrc_enable strobes with tx_bit=0 -> pcrc_val stays 13'h0000.
REQ-032 tx_bit=1 strobe with stuff_bit=1, then tx_bit=1 strobe with stuff_bit=0 -> pcrc_val=13'h19E7.
REQ-033 Accumulate 13'h19E7, pcrc_send, 13 bit_ticks (one with stuff_bit=1 inserted, 14 total) -> pcrc_bit sequence 1,1,0,0,1,1,1,1,0,0,1,1,1; pcrc_busy high throughout; pcrc_done single pulse after the last tick; a reference accumulator fed data plus these bits ends at 13'h0000.
REQ-034 initialize after 5 accepted ticks in SEND -> next cycle pcrc_busy=0, pcrc_val=0, pcrc_bit=0, no pcrc_done.
REQ-035 initialize and pcrc_send asserted in the same cycle -> stays ACCUM, pcrc_val=0, pcrc_busy=0.
